systolic_mac_array: RTL

Parametrised N×N output-stationary systolic matrix multiplier computing C = A·B for square integer matrices. It is the generalised successor of the fixed 4×4 int8 array. It adds configurable dimension and widths, a runtime signed/unsigned mode, a valid/ready handshake on input and output, and output hold under backpressure. It sits between the operand staging buffers and the result writeback logic of the MAC datapath.

---
 rtl/systolic_mac_array.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/systolic_mac_array.sv
// systolic_mac_array: N x N output-stationary systolic matrix multiplier, C = A * B.
//
// Ports
//   clk, reset      single clock, synchronous active-high reset
//   valid_in        operand set offered; accepted when ready_in is also high
//   ready_in        high only in IDLE while reset is low
//   signed_mode     1 = two's-complement operands, 0 = unsigned; latched at accept
//   matrix_A/B      N*N elements of DATA_W bits, element [0][0] in the MSBs
//   y               N*N results of ACC_W bits, element [0][0] in the MSBs
//   valid_out       y holds a complete result (DONE state)
//   ready_out       consumer takes the result
//   busy            high in LOAD, RUN and DONE
//
// Flow: IDLE -accept-> LOAD (1 cycle) -> RUN (3N-1 cycles) -> DONE -ready_out-> IDLE.
// Results live in the PE accumulators, so y holds from DONE until the next LOAD.

// One processing element: accumulates ext(a)*ext(b) at ACC_W bits, wrapping.
module systolic_mac_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic              sgn,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] a_ext, b_ext, prod;

  always_comb begin
    // Two's-complement product modulo 2^ACC_W is the same as the unsigned
    // product of the sign-extended operands, so one multiplier covers both modes.
    a_ext = {{(ACC_W-DATA_W){sgn & a[DATA_W-1]}}, a};
    b_ext = {{(ACC_W-DATA_W){sgn & b[DATA_W-1]}}, b};
    prod  = a_ext * b_ext;
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + prod;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule

module systolic_mac_array #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic                    signed_mode,
  input  logic [N*N*DATA_W-1:0]   matrix_A,
  input  logic [N*N*DATA_W-1:0]   matrix_B,
  output logic [N*N*ACC_W-1:0]    y,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic                    busy
);
  // Feeder length: up to N-1 skew zeros followed by N operands.
  localparam int L  = 2*N-1;
  localparam int CW = $clog2(3*N);
  localparam logic [CW-1:0] RUN_LAST = CW'(3*N-2);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            sgn_q, sgn_d;
  logic [N*N*DATA_W-1:0]           a_lat_q, a_lat_d, b_lat_q, b_lat_d;
  // fa: row feeder i, fb: column feeder j; slot 0 is the registered output.
  logic [N-1:0][L-1:0][DATA_W-1:0] fa_q, fa_d, fb_q, fb_d;
  // Inter-PE operand registers: a moves right, b moves down.
  logic [N-1:0][N-2:0][DATA_W-1:0] a_pipe_q, a_pipe_d;
  logic [N-2:0][N-1:0][DATA_W-1:0] b_pipe_q, b_pipe_d;
  // Operand seen by PE(i,j) in the current cycle.
  logic [N-1:0][N-1:0][DATA_W-1:0] a_op, b_op;
  logic [N-1:0][N-1:0][ACC_W-1:0]  acc;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    a_lat_d  = a_lat_q;
    b_lat_d  = b_lat_q;
    fa_d     = fa_q;
    fb_d     = fb_q;
    a_pipe_d = a_pipe_q;
    b_pipe_d = b_pipe_q;
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          a_lat_d = matrix_A;
          b_lat_d = matrix_B;
          sgn_d   = signed_mode;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d  = RUN;
        cnt_d    = '0;
        fa_d     = '0;
        fb_d     = '0;
        a_pipe_d = '0;
        b_pipe_d = '0;
        // Row i of A skewed by i slots; column j of B skewed by j slots.
        for (int i = 0; i < N; i++) begin
          for (int k = 0; k < N; k++) begin
            fa_d[i][i+k] = a_lat_q[(N*N-1-(i*N+k))*DATA_W +: DATA_W];
            fb_d[i][i+k] = b_lat_q[(N*N-1-(k*N+i))*DATA_W +: DATA_W];
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        for (int i = 0; i < N; i++) begin
          for (int s = 0; s < L-1; s++) begin
            fa_d[i][s] = fa_q[i][s+1];
            fb_d[i][s] = fb_q[i][s+1];
          end
          fa_d[i][L-1] = '0;
          fb_d[i][L-1] = '0;
        end
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N-1; j++)
            a_pipe_d[i][j] = a_op[i][j];
        for (int i = 0; i < N-1; i++)
          for (int j = 0; j < N; j++)
            b_pipe_d[i][j] = b_op[i][j];
        // Last product lands at the end of RUN cycle 3N-2; one slack cycle follows.
        if (cnt_q == RUN_LAST) state_d = DONE;
      end
      DONE: begin
        if (ready_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      a_lat_q  <= '0;
      b_lat_q  <= '0;
      fa_q     <= '0;
      fb_q     <= '0;
      a_pipe_q <= '0;
      b_pipe_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      a_lat_q  <= a_lat_d;
      b_lat_q  <= b_lat_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      a_pipe_q <= a_pipe_d;
      b_pipe_q <= b_pipe_d;
    end
  end

  assign ready_in  = (state_q == IDLE) && !reset;
  assign valid_out = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign a_op[i][j] = fa_q[i][0];
      end else begin : g_a_int
        assign a_op[i][j] = a_pipe_q[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_op[i][j] = fb_q[j][0];
      end else begin : g_b_int
        assign b_op[i][j] = b_pipe_q[i-1][j];
      end

      systolic_mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == LOAD),
        .en    (state_q == RUN),
        .sgn   (sgn_q),
        .a     (a_op[i][j]),
        .b     (b_op[i][j]),
        .acc   (acc[i][j])
      );

      assign y[(N*N-1-(i*N+j))*ACC_W +: ACC_W] = acc[i][j];
    end
  end
endmodule
